// File: rtl/jtag_bist_pkg.sv
// Shared TAP state encoding, opcodes and instruction decode for the BIST TAP.
// Optional feature macro: JTAG_IDCODE_EN (IDCODE instruction and register present).
package jtag_bist_pkg;

  localparam int IR_W_DEF = 4;

  typedef enum logic [3:0] {
    S_TLR, S_RTI,
    S_SEL_DR, S_CAP_DR, S_SHIFT_DR, S_EXIT1_DR, S_PAUSE_DR, S_EXIT2_DR, S_UPD_DR,
    S_SEL_IR, S_CAP_IR, S_SHIFT_IR, S_EXIT1_IR, S_PAUSE_IR, S_EXIT2_IR, S_UPD_IR
  } tap_state_t;

  localparam logic [3:0] OP_BYPASS   = 4'hF;
  localparam logic [3:0] OP_IDCODE   = 4'h1;
  localparam logic [3:0] OP_BIST_CFG = 4'h8;
  localparam logic [3:0] OP_RUNBIST  = 4'h9;
  localparam logic [3:0] OP_BIST_SIG = 4'hA;
  localparam logic [3:0] IR_CAPTURE  = 4'b0001;

`ifdef JTAG_IDCODE_EN
  localparam logic [3:0] IR_RESET = OP_IDCODE;
`else
  localparam logic [3:0] IR_RESET = OP_BYPASS;
`endif

  // Collapses every unimplemented opcode onto BYPASS.
  function automatic logic [3:0] decode_op(input logic [3:0] ir);
    case (ir)
`ifdef JTAG_IDCODE_EN
      OP_IDCODE:   return ir;
`endif
      OP_BIST_CFG: return ir;
      OP_RUNBIST:  return ir;
      OP_BIST_SIG: return ir;
      default:     return OP_BYPASS;
    endcase
  endfunction

endpackage

// File: rtl/jtag_tap_fsm.sv
// 16-state IEEE 1149.1 TAP controller; advances only on clk cycles with tck_en=1.
module jtag_tap_fsm
  import jtag_bist_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       tck_en,
  input  logic       tms,
  output tap_state_t state
);

  tap_state_t r_state;
  tap_state_t w_state_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_TLR;
    else if (tck_en) r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_TLR:      w_state_next = tms ? S_TLR      : S_RTI;
      S_RTI:      w_state_next = tms ? S_SEL_DR   : S_RTI;
      S_SEL_DR:   w_state_next = tms ? S_SEL_IR   : S_CAP_DR;
      S_CAP_DR:   w_state_next = tms ? S_EXIT1_DR : S_SHIFT_DR;
      S_SHIFT_DR: w_state_next = tms ? S_EXIT1_DR : S_SHIFT_DR;
      S_EXIT1_DR: w_state_next = tms ? S_UPD_DR   : S_PAUSE_DR;
      S_PAUSE_DR: w_state_next = tms ? S_EXIT2_DR : S_PAUSE_DR;
      S_EXIT2_DR: w_state_next = tms ? S_UPD_DR   : S_SHIFT_DR;
      S_UPD_DR:   w_state_next = tms ? S_SEL_DR   : S_RTI;
      S_SEL_IR:   w_state_next = tms ? S_TLR      : S_CAP_IR;
      S_CAP_IR:   w_state_next = tms ? S_EXIT1_IR : S_SHIFT_IR;
      S_SHIFT_IR: w_state_next = tms ? S_EXIT1_IR : S_SHIFT_IR;
      S_EXIT1_IR: w_state_next = tms ? S_UPD_IR   : S_PAUSE_IR;
      S_PAUSE_IR: w_state_next = tms ? S_EXIT2_IR : S_PAUSE_IR;
      S_EXIT2_IR: w_state_next = tms ? S_UPD_IR   : S_SHIFT_IR;
      S_UPD_IR:   w_state_next = tms ? S_SEL_DR   : S_RTI;
      default:    w_state_next = S_TLR;
    endcase
  end

  always_comb begin
    state = r_state;
  end

endmodule

// File: rtl/jtag_bist_tap.sv
// TAP + instruction decoder driving BIST FSM controls and capturing its signature/result.
// Optional feature macro: JTAG_IDCODE_EN (adds the 32-bit IDCODE register; reset IR becomes IDCODE).
module jtag_bist_tap
  import jtag_bist_pkg::*;
#(
  parameter int IR_W   = IR_W_DEF,
  parameter int ADDR_W = 8,
  parameter int SIG_W  = 14,
  parameter int RES_W  = 4
`ifdef JTAG_IDCODE_EN
  ,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tck_en,
  input  logic              tms,
  input  logic              tdi,
  output logic              tdo,
  output logic              tdo_oe,
  input  logic [SIG_W-1:0]  bist_signature,
  input  logic [RES_W-1:0]  bist_result,
  output logic              runbist_en,
  output logic              idle_en,
  output logic [ADDR_W-1:0] start_addr,
  output logic [ADDR_W-1:0] end_addr,
  output logic              cfg_err
);

  tap_state_t              w_state;
  logic [IR_W-1:0]         r_ir, r_ir_sr, w_op;
  logic                    r_bypass_sr;
  logic [2*ADDR_W-1:0]     r_cfg_sr;
  logic [RES_W+SIG_W-1:0]  r_sig_sr;
  logic [ADDR_W-1:0]       r_start, r_end, w_cfg_start, w_cfg_end;
  logic                    r_cfg_err, r_runbist_en, r_idle_en, w_dr_lsb;
`ifdef JTAG_IDCODE_EN
  logic [31:0]             r_idcode_sr;
`endif

  jtag_tap_fsm u_fsm (
    .clk    (clk),
    .rst    (rst),
    .tck_en (tck_en),
    .tms    (tms),
    .state  (w_state)
  );

  assign w_op        = decode_op(r_ir);
  assign w_cfg_start = r_cfg_sr[ADDR_W-1:0];
  assign w_cfg_end   = r_cfg_sr[2*ADDR_W-1:ADDR_W];

  // IR returns to its reset opcode on every clk spent in TEST_LOGIC_RESET.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ir    <= IR_RESET;
      r_ir_sr <= '0;
    end else if (w_state == S_TLR) begin
      r_ir <= IR_RESET;
    end else if (tck_en) begin
      case (w_state)
        S_CAP_IR:   r_ir_sr <= IR_CAPTURE;
        S_SHIFT_IR: r_ir_sr <= {tdi, r_ir_sr[IR_W-1:1]};
        S_UPD_IR:   r_ir    <= r_ir_sr;
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bypass_sr <= 1'b0;
      r_cfg_sr    <= '0;
      r_sig_sr    <= '0;
`ifdef JTAG_IDCODE_EN
      r_idcode_sr <= '0;
`endif
    end else if (tck_en && w_state == S_CAP_DR) begin
      case (w_op)
        OP_BIST_CFG: r_cfg_sr <= {r_end, r_start};
        OP_BIST_SIG: r_sig_sr <= {bist_result, bist_signature};
`ifdef JTAG_IDCODE_EN
        OP_IDCODE:   r_idcode_sr <= IDCODE_VAL;
`endif
        default:     r_bypass_sr <= 1'b0;
      endcase
    end else if (tck_en && w_state == S_SHIFT_DR) begin
      case (w_op)
        OP_BIST_CFG: r_cfg_sr <= {tdi, r_cfg_sr[2*ADDR_W-1:1]};
        OP_BIST_SIG: r_sig_sr <= {tdi, r_sig_sr[RES_W+SIG_W-1:1]};
`ifdef JTAG_IDCODE_EN
        OP_IDCODE:   r_idcode_sr <= {tdi, r_idcode_sr[31:1]};
`endif
        default:     r_bypass_sr <= tdi;
      endcase
    end
  end

  // A range with end below start is rejected and leaves the previous window in place.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_start   <= '0;
      r_end     <= '0;
      r_cfg_err <= 1'b0;
    end else if (tck_en && w_state == S_UPD_DR && w_op == OP_BIST_CFG) begin
      if (w_cfg_end >= w_cfg_start) begin
        r_start   <= w_cfg_start;
        r_end     <= w_cfg_end;
        r_cfg_err <= 1'b0;
      end else begin
        r_cfg_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_runbist_en <= 1'b0;
      r_idle_en    <= 1'b0;
    end else begin
      r_runbist_en <= (w_op == OP_RUNBIST) && (w_state != S_TLR);
      r_idle_en    <= (w_op == OP_RUNBIST) && (w_state == S_RTI);
    end
  end

  always_comb begin
    w_dr_lsb = r_bypass_sr;
    case (w_op)
      OP_BIST_CFG: w_dr_lsb = r_cfg_sr[0];
      OP_BIST_SIG: w_dr_lsb = r_sig_sr[0];
`ifdef JTAG_IDCODE_EN
      OP_IDCODE:   w_dr_lsb = r_idcode_sr[0];
`endif
      default:     w_dr_lsb = r_bypass_sr;
    endcase
  end

  assign tdo_oe     = (w_state == S_SHIFT_IR) || (w_state == S_SHIFT_DR);
  assign tdo        = (w_state == S_SHIFT_IR) ? r_ir_sr[0] :
                      (w_state == S_SHIFT_DR) ? w_dr_lsb : 1'b0;
  assign runbist_en = r_runbist_en;
  assign idle_en    = r_idle_en;
  assign start_addr = r_start;
  assign end_addr   = r_end;
  assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_jtag_bist_tap.sv
// Self-checking bench for jtag_bist_tap: randomized scans checked against a behavioural TAP model.
module tb_jtag_bist_tap;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tck_en = 1'b0;
  logic        tms = 1'b0;
  logic        tdi = 1'b0;
  logic        tdo, tdo_oe, runbist_en, idle_en, cfg_err;
  logic [13:0] bist_signature = '0;
  logic [3:0]  bist_result = '0;
  logic [7:0]  start_addr, end_addr;

  int checks = 0;
  int errors = 0;

  // Behavioural model: current instruction and BIST window registers.
  logic [3:0] m_ir;
  logic [7:0] m_start, m_end;
  logic       m_err;

`ifdef JTAG_IDCODE_EN
  localparam logic [3:0] M_IR_RESET = 4'h1;
`else
  localparam logic [3:0] M_IR_RESET = 4'hF;
`endif

  jtag_bist_tap dut (
    .clk            (clk),
    .rst            (rst),
    .tck_en         (tck_en),
    .tms            (tms),
    .tdi            (tdi),
    .tdo            (tdo),
    .tdo_oe         (tdo_oe),
    .bist_signature (bist_signature),
    .bist_result    (bist_result),
    .runbist_en     (runbist_en),
    .idle_en        (idle_en),
    .start_addr     (start_addr),
    .end_addr       (end_addr),
    .cfg_err        (cfg_err)
  );

  always #5 clk = ~clk;

  function automatic int dr_len(input logic [3:0] ir);
    case (ir)
      4'h8: return 16;
      4'hA: return 18;
`ifdef JTAG_IDCODE_EN
      4'h1: return 32;
`endif
      default: return 1;
    endcase
  endfunction

  function automatic logic [31:0] dr_cap(input logic [3:0] ir);
    case (ir)
      4'h8: return {16'h0, m_end, m_start};
      4'hA: return {14'h0, bist_result, bist_signature};
`ifdef JTAG_IDCODE_EN
      4'h1: return 32'h1000_0001;
`endif
      default: return 32'h0;
    endcase
  endfunction

  // Expected tdo stream: captured bits first, then tdi delayed by the register length.
  function automatic logic [31:0] expect_stream(input logic [3:0] ir, input logic [31:0] din, input int n);
    logic [31:0] cap, res;
    int len;
    cap = dr_cap(ir);
    len = dr_len(ir);
    res = '0;
    for (int i = 0; i < n; i++) res[i] = (i < len) ? cap[i] : din[i-len];
    return res;
  endfunction

  task automatic tick(input logic t_tms, input logic t_tdi);
    tms = t_tms;
    tdi = t_tdi;
    tck_en = 1'b1;
    @(posedge clk);
    #1;
    tck_en = 1'b0;
  endtask

  task automatic idle_clks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic goto_tlr();
    repeat (5) tick(1'b1, 1'b0);
    m_ir = M_IR_RESET;
  endtask

  // Starts and ends in RUN_TEST_IDLE.
  task automatic scan_ir(input logic [3:0] val, output logic [3:0] cap);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 4; i++) begin
      cap[i] = tdo;
      tick(i == 3, val[i]);
    end
    tick(1, 0); tick(0, 0);
    m_ir = val;
  endtask

  task automatic scan_dr(input logic [31:0] din, input int n, output logic [31:0] dout);
    logic [31:0] sr;
    dout = '0;
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < n; i++) begin
      dout[i] = tdo;
      tick(i == n - 1, din[i]);
    end
    tick(1, 0); tick(0, 0);
    if (m_ir == 4'h8) begin
      sr = din;
      if (sr[15:8] >= sr[7:0]) begin
        m_start = sr[7:0];
        m_end = sr[15:8];
        m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({tdo, tdo_oe, runbist_en, idle_en, start_addr, end_addr, cfg_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {tdo, tdo_oe, runbist_en, idle_en, start_addr, end_addr, cfg_err});
    end
    @(negedge clk);
    rst = 1'b1;
    idle_clks(1);
    tick(0, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    checks++;
    if (tdo_oe !== 1'b1) begin
      errors++;
      $display("FAIL shift_dr_oe: got %b expected 1", tdo_oe);
    end
    goto_tlr();
    tick(0, 0);
    idle_clks(1);
    checks++;
    if ({tdo_oe, runbist_en, idle_en, start_addr, end_addr, cfg_err} !== '0) begin
      errors++;
      $display("FAIL tlr_outputs: got %b expected all zero",
               {tdo_oe, runbist_en, idle_en, start_addr, end_addr, cfg_err});
    end
    $display("reset: tlr reached, outputs idle");
  endtask

  task automatic test_idcode();
    logic [31:0] din, dout, exp;
    din = $urandom;
    exp = expect_stream(m_ir, din, 32);
    scan_dr(din, 32, dout);
    checks++;
    if (dout !== exp) begin
      errors++;
      $display("FAIL idcode_scan: got %h expected %h", dout, exp);
    end
    $display("idcode: ir=%h tdo stream %h", m_ir, dout);
  endtask

  task automatic test_bist_cfg();
    logic [3:0]  cap;
    logic [31:0] dout, din;
    logic [7:0]  s, e;
    scan_ir(4'h8, cap);
    checks++;
    if (cap !== 4'b0001) begin
      errors++;
      $display("FAIL ir_capture: got %b expected 0001", cap);
    end
    for (int k = 0; k < 8; k++) begin
      if (k == 0) begin s = 8'h00; e = 8'h02; end
      else if (k == 1) begin s = 8'h05; e = 8'h01; end
      else begin
        s = 8'($urandom_range(0, 255));
        e = ($urandom_range(0, 2) == 0) ? s : 8'($urandom_range(0, 255));
      end
      din = {16'h0, e, s};
      scan_dr(din, 16, dout);
      checks++;
      if ({start_addr, end_addr, cfg_err} !== {m_start, m_end, m_err}) begin
        errors++;
        $display("FAIL bist_cfg[%0d]: got start=%h end=%h err=%b expected start=%h end=%h err=%b",
                 k, start_addr, end_addr, cfg_err, m_start, m_end, m_err);
      end
      $display("bist_cfg: shift end=%h start=%h -> start=%h end=%h err=%b", e, s, start_addr, end_addr, cfg_err);
    end
  endtask

  task automatic test_runbist();
    logic [3:0] cap;
    scan_ir(4'h9, cap);
    idle_clks(1);
    checks++;
    if ({runbist_en, idle_en} !== 2'b11) begin
      errors++;
      $display("FAIL runbist_rti: got run=%b idle=%b expected 1 1", runbist_en, idle_en);
    end
    tick(1, 0);
    idle_clks(1);
    checks++;
    if ({runbist_en, idle_en} !== 2'b10) begin
      errors++;
      $display("FAIL runbist_seldr: got run=%b idle=%b expected 1 0", runbist_en, idle_en);
    end
    tick(0, 0); tick(1, 0); tick(1, 0); tick(0, 0);
    scan_ir(4'hF, cap);
    idle_clks(1);
    checks++;
    if ({runbist_en, idle_en} !== 2'b00) begin
      errors++;
      $display("FAIL runbist_bypass: got run=%b idle=%b expected 0 0", runbist_en, idle_en);
    end
    scan_ir(4'h9, cap);
    goto_tlr();
    idle_clks(1);
    checks++;
    if ({runbist_en, idle_en} !== 2'b00) begin
      errors++;
      $display("FAIL runbist_tlr: got run=%b idle=%b expected 0 0", runbist_en, idle_en);
    end
    tick(0, 0);
    $display("runbist: enable/idle sequencing exercised");
  endtask

  task automatic test_bypass();
    logic [3:0]  cap, op;
    logic [31:0] din, dout, exp;
    for (int k = 0; k < 3; k++) begin
      do op = 4'($urandom_range(0, 15));
      while (op == 4'h8 || op == 4'h9 || op == 4'hA || op == 4'h1);
      scan_ir(op, cap);
      din = 32'($urandom_range(0, 255));
      exp = expect_stream(m_ir, din, 8);
      scan_dr(din, 8, dout);
      checks++;
      if (dout[7:0] !== exp[7:0]) begin
        errors++;
        $display("FAIL bypass_op_%h: got %h expected %h", op, dout[7:0], exp[7:0]);
      end
      $display("bypass: op=%h din=%h tdo=%h", op, din[7:0], dout[7:0]);
    end
  endtask

  task automatic test_bist_sig();
    logic [3:0]  cap;
    logic [31:0] dout, exp;
    scan_ir(4'hA, cap);
    for (int k = 0; k < 4; k++) begin
      if (k == 0) begin
        bist_signature = 14'h2A5C;
        bist_result = 4'h3;
      end else begin
        bist_signature = 14'($urandom);
        bist_result = 4'($urandom);
      end
      exp = expect_stream(m_ir, 32'h0, 18);
      if (k == 0) exp = 32'h0EA5C;
      scan_dr(32'h0, 18, dout);
      checks++;
      if (dout[17:0] !== exp[17:0]) begin
        errors++;
        $display("FAIL bist_sig[%0d]: got %h expected %h", k, dout[17:0], exp[17:0]);
      end
      $display("bist_sig: sig=%h res=%h tdo stream %h", bist_signature, bist_result, dout[17:0]);
    end
  endtask

  task automatic test_hold_and_async();
    logic [3:0]  cap;
    logic [31:0] din;
    logic        held;
    scan_ir(4'h8, cap);
    din = {16'h0, 8'hC3, 8'h41};
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 5; i++) tick(0, din[i]);
    held = tdo;
    for (int c = 0; c < 10; c++) begin
      tms = 1'($urandom);
      tdi = 1'($urandom);
      @(posedge clk);
      #1;
      checks++;
      if ({tdo_oe, tdo} !== {1'b1, held}) begin
        errors++;
        $display("FAIL hold_cycle%0d: got oe=%b tdo=%b expected oe=1 tdo=%b", c, tdo_oe, tdo, held);
      end
    end
    for (int i = 5; i < 16; i++) tick(i == 15, din[i]);
    tick(1, 0); tick(0, 0);
    m_start = 8'h41; m_end = 8'hC3; m_err = 1'b0;
    checks++;
    if ({start_addr, end_addr, cfg_err} !== {m_start, m_end, m_err}) begin
      errors++;
      $display("FAIL hold_update: got start=%h end=%h err=%b expected 41 c3 0", start_addr, end_addr, cfg_err);
    end
    $display("hold: 10 gated cycles, final start=%h end=%h", start_addr, end_addr);
    tick(1, 0); tick(0, 0); tick(0, 0);
    for (int i = 0; i < 6; i++) tick(0, 1'($urandom));
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({tdo, tdo_oe, runbist_en, idle_en, start_addr, end_addr, cfg_err} !== '0) begin
      errors++;
      $display("FAIL async_reset: got %b expected all zero",
               {tdo, tdo_oe, runbist_en, idle_en, start_addr, end_addr, cfg_err});
    end
    @(negedge clk);
    rst = 1'b1;
    m_ir = M_IR_RESET; m_start = '0; m_end = '0; m_err = 1'b0;
    idle_clks(1);
    tick(0, 0);
    $display("async_reset: outputs cleared mid-shift");
  endtask

  initial begin
    m_ir = M_IR_RESET; m_start = '0; m_end = '0; m_err = 1'b0;
    #2;
    test_reset();
    test_idcode();
    test_bist_cfg();
    test_runbist();
    test_bypass();
    test_bist_sig();
    test_hold_and_async();
    test_idcode();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
